// File: rtl/risc_pkg.sv
// Shared core types: ALU opcodes, ALU request bundle, ALU function.
// The ALU is purely combinational; undefined opcodes produce zero.
package risc_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    SLL  = 4'd2,
    SRL  = 4'd3,
    SRA  = 4'd4,
    XOR  = 4'd5,
    OR   = 4'd6,
    AND  = 4'd7,
    SLT  = 4'd8,
    SLTU = 4'd9
  } alu_op_t;

  typedef struct packed {
    alu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
  } alu_req_t;

  function automatic logic [31:0] alu_exec(
    input alu_req_t r
  );
    logic [31:0] res;
    logic [4:0]  sh;
    sh  = r.b[4:0];
    res = '0;
    case (r.op)
      ADD:  res = r.a + r.b;
      SUB:  res = r.a - r.b;
      SLL:  res = r.a << sh;
      SRL:  res = r.a >> sh;
      SRA:  res = $unsigned($signed(r.a) >>> sh);
      XOR:  res = r.a ^ r.b;
      OR:   res = r.a | r.b;
      AND:  res = r.a & r.b;
      SLT:  res = {31'b0, $signed(r.a) < $signed(r.b)};
      SLTU: res = {31'b0, r.a < r.b};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Round-robin picker: first valid request after last_grant wins.
// Purely combinational; one-hot win plus binary index.
module alu_rr_arbiter_rr_pick #(
  parameter  int N    = 2,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_grant,
  output logic [N-1:0]    win,
  output logic [ID_W-1:0] win_idx,
  output logic            win_any
);

  int   idx;
  logic found;

  // Scan N slots starting one past the previous winner, wrapping.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_idx  = ID_W'(idx);
      end
    end
    win_any = found;
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU among N_REQ requesters.
// Result lands in a single registered slot tagged with id and tag.
module alu_rr_arbiter
  import risc_pkg::*;
#(
  parameter  int N_REQ = 2,
  parameter  int TAG_W = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ-1:0][ALU_OP_W-1:0]   req_op,
  input  logic [N_REQ-1:0][31:0]           req_a,
  input  logic [N_REQ-1:0][31:0]           req_b,
  input  logic [N_REQ-1:0][TAG_W-1:0]      req_tag,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [ID_W-1:0]                  rsp_id,
  output logic [TAG_W-1:0]                 rsp_tag,
  output logic [31:0]                      rsp_res
);

  logic [ID_W-1:0]  last_grant;
  logic [N_REQ-1:0] win;
  logic [ID_W-1:0]  win_idx;
  logic             win_any;
  logic             slot_free;
  logic             xfer;
  alu_req_t         alu_in;
  logic [31:0]      alu_res;

  alu_rr_arbiter_rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .win        (win),
    .win_idx    (win_idx),
    .win_any    (win_any)
  );

  assign slot_free = !rsp_valid || rsp_ready;
  assign req_ready = win & {N_REQ{slot_free && !rst}};
  assign xfer      = |req_ready;

  // Drive the shared ALU from the winner, or a benign ADD 0+0 when idle.
  always_comb begin
    alu_in.op = ADD;
    alu_in.a  = '0;
    alu_in.b  = '0;
    if (win_any) begin
      alu_in.op = alu_op_t'(req_op[win_idx]);
      alu_in.a  = req_a[win_idx];
      alu_in.b  = req_b[win_idx];
    end
  end

  assign alu_res = alu_exec(alu_in);

  // Response slot and pointer: load on transfer, clear valid on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_tag    <= '0;
      rsp_res    <= '0;
      last_grant <= ID_W'(N_REQ - 1);
    end else if (xfer) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= win_idx;
      rsp_tag    <= req_tag[win_idx];
      rsp_res    <= alu_res;
      last_grant <= win_idx;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: op table on requester 0,
// then hand sequences for arbitration, back-pressure and reset.
module tb_alu_rr_arbiter;
  import risc_pkg::*;

  localparam int N_REQ = 2;
  localparam int TAG_W = 4;
  localparam int ID_W  = 1;

  logic                           clk;
  logic                           rst;
  logic [N_REQ-1:0]               req_valid;
  logic [N_REQ-1:0]               req_ready;
  logic [N_REQ-1:0][ALU_OP_W-1:0] req_op;
  logic [N_REQ-1:0][31:0]         req_a;
  logic [N_REQ-1:0][31:0]         req_b;
  logic [N_REQ-1:0][TAG_W-1:0]    req_tag;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [ID_W-1:0]                rsp_id;
  logic [TAG_W-1:0]               rsp_tag;
  logic [31:0]                    rsp_res;

  int n_cmp = 0;
  int n_bad = 0;

  alu_rr_arbiter #(
    .N_REQ (N_REQ),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_tag   (rsp_tag),
    .rsp_res   (rsp_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] res;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag);
    req_op[i]  = op;
    req_a[i]   = a;
    req_b[i]   = b;
    req_tag[i] = tag;
  endtask

  initial begin
    vt[0]  = '{ADD,  32'd5,          32'd7,        4'd3, 32'd12};
    vt[1]  = '{SUB,  32'd10,         32'd3,        4'd1, 32'd7};
    vt[2]  = '{SLL,  32'd1,          32'h21,       4'd2, 32'd2};
    vt[3]  = '{SRL,  32'h8000_0000,  32'd4,        4'd4, 32'h0800_0000};
    vt[4]  = '{SRA,  32'h8000_0000,  32'd4,        4'd5, 32'hF800_0000};
    vt[5]  = '{XOR,  32'hF0F0,       32'h0FF0,     4'd6, 32'hFF00};
    vt[6]  = '{OR,   32'hF0,         32'h0F,       4'd7, 32'hFF};
    vt[7]  = '{AND,  32'hF0,         32'h3C,       4'd8, 32'h30};
    vt[8]  = '{SLT,  32'hFFFF_FFFF,  32'd1,        4'd9, 32'd1};
    vt[9]  = '{SLTU, 32'hFFFF_FFFF,  32'd1,        4'hA, 32'd0};
    vt[10] = '{4'hB, 32'd3,          32'd4,        4'hB, 32'd0};

    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;

    // Reset state, with a request visible while reset is held.
    #2;
    req_valid = 2'b01;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_rsp_tag",   32'(rsp_tag),   32'd0);
    chk("rst_rsp_res",   rsp_res,        32'd0);
    req_valid = '0;
    step();
    rst = 1'b0;

    // Op table on requester 0, one result per cycle.
    for (int i = 0; i < 11; i++) begin
      set_req(0, vt[i].op, vt[i].a, vt[i].b, vt[i].tag);
      req_valid = 2'b01;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'd1);
      step();
      chk($sformatf("v%0d_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("v%0d_id", i),    32'(rsp_id),    32'd0);
      chk($sformatf("v%0d_tag", i),   32'(rsp_tag),   32'(vt[i].tag));
      chk($sformatf("v%0d_res", i),   rsp_res,        vt[i].res);
    end

    // Fresh reset, then two requesters continuously valid.
    req_valid = '0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    set_req(0, SUB, 32'd10, 32'd3, 4'd2);
    set_req(1, SRA, 32'h8000_0000, 32'd4, 4'd6);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_ready", i), 32'(req_ready),
          (i % 2 == 0) ? 32'd1 : 32'd2);
      step();
      chk($sformatf("rr%0d_id", i), 32'(rsp_id), 32'(i % 2));
      chk($sformatf("rr%0d_res", i), rsp_res,
          (i % 2 == 0) ? 32'd7 : 32'hF800_0000);
      chk($sformatf("rr%0d_tag", i), 32'(rsp_tag),
          (i % 2 == 0) ? 32'd2 : 32'd6);
    end

    // Drain without refill: valid drops, data held.
    req_valid = '0;
    step();
    chk("drain_valid", 32'(rsp_valid), 32'd0);
    chk("drain_res",   rsp_res,        32'hF800_0000);
    chk("drain_id",    32'(rsp_id),    32'd1);

    // Load a pending result from requester 0 (pointer -> 0).
    set_req(0, ADD, 32'd1, 32'd1, 4'd5);
    req_valid = 2'b01;
    step();
    chk("bp_load_res", rsp_res, 32'd2);

    // Back-pressure with requester 1 waiting: nothing moves.
    rsp_ready = 1'b0;
    set_req(1, XOR, 32'hF0, 32'h0F, 4'd9);
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d_ready", i), 32'(req_ready), 32'd0);
      step();
      chk($sformatf("bp%0d_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d_id", i),    32'(rsp_id),    32'd0);
      chk($sformatf("bp%0d_tag", i),   32'(rsp_tag),   32'd5);
      chk($sformatf("bp%0d_res", i),   rsp_res,        32'd2);
    end

    // Slot frees and requester 0 joins: 1 still wins, no bubble.
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("bp_rel_ready", 32'(req_ready), 32'd2);
    step();
    chk("bp_rel_valid", 32'(rsp_valid), 32'd1);
    chk("bp_rel_id",    32'(rsp_id),    32'd1);
    chk("bp_rel_tag",   32'(rsp_tag),   32'd9);
    chk("bp_rel_res",   rsp_res,        32'hFF);
    #1;
    chk("bp_next_ready", 32'(req_ready), 32'd1);
    step();
    chk("bp_next_id",  32'(rsp_id), 32'd0);
    chk("bp_next_res", rsp_res,     32'd2);

    // Get requester 1 granted so the pointer sits at 1.
    req_valid = 2'b10;
    step();
    chk("pre_rst_id",    32'(rsp_id),    32'd1);
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);

    // Asynchronous reset between edges drops the slot at once.
    req_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_res",   rsp_res,        32'd0);
    #1;
    rst = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    step();
    chk("post_rst_id",  32'(rsp_id), 32'd0);
    chk("post_rst_res", rsp_res,     32'd2);

    req_valid = '0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one combinational ALU datapath between N_REQ requesters, for example the integer issue slot and the address/branch-compare unit.
- Each requester uses a valid/ready handshake. A round-robin grant picks one requester per cycle.
- The ALU result is captured in a single registered response slot, tagged with the winner's index and a passthrough tag.
- Sits between the decode/issue logic and the shared ALU. It is the only driver of the ALU's alu_op/alu_a/alu_b inputs.

Parameters:
- N_REQ, 2, number of requesters; legal range 2..8.
- TAG_W, 4, width of the opaque per-request tag returned with the result.
- ID_W, $clog2(N_REQ), derived; width of the requester index. Not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit set per cycle.
- req_op  in  N_REQ x alu_op_t  per-requester ALU operation.
- req_a  in  N_REQ x 32  operand A.
- req_b  in  N_REQ x 32  operand B.
- req_tag  in  N_REQ x TAG_W  opaque tag.
- rsp_valid  out  1  response slot holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  ID_W  index of the requester that produced the result.
- rsp_tag  out  TAG_W  tag of that request.
- rsp_res  out  32  ALU result.

Behaviour:
- Reset: asynchronous, active-high.
  - rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_res=0.
  - Round-robin pointer last_grant=N_REQ-1, so requester 0 has top priority after reset.
  - req_ready is combinational and is 0 while rst is high.
- Slot free: slot_free = !rsp_valid || rsp_ready.
- Grant (combinational):
  - Search starts at (last_grant+1) mod N_REQ and wraps around.
  - The first i with req_valid[i]=1 wins.
  - req_ready[i] = win[i] && slot_free && !rst.
  - If no requester is valid, req_ready is all zeros.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - Requesters must hold op/a/b/tag stable while valid && !ready, and must not drop valid before acceptance.
  - req_valid must not depend combinationally on req_ready.
  - req_ready may depend on req_valid of all requesters.
- ALU drive: the shared ALU sees the winner's op/a/b every cycle. When no requester wins, op=ADD and a=b=0.
- Accept (same edge as the transfer):
  - rsp_res <= ALU output.
  - rsp_id <= winner index.
  - rsp_tag <= winner's tag.
  - rsp_valid <= 1.
  - last_grant <= winner.
- Pointer update: last_grant changes only on an accepted transfer. A grant blocked by back-pressure does not rotate the pointer.
- Latency: exactly 1 cycle from the accept edge to rsp_valid=1.
- Throughput: 1 result per cycle with rsp_ready held high.
- Drain without refill: rsp_valid && rsp_ready with no transfer → rsp_valid <= 0. The data fields hold their last values.
- Back-pressure: rsp_valid && !rsp_ready → slot held unchanged, all req_ready=0.
- Simultaneous drain and accept in the same cycle: the slot is overwritten with the new result and rsp_valid stays 1. No bubble.
- Fairness: with all N_REQ requesters continuously valid, each is granted exactly once in every N_REQ consecutive accepts.
- ALU rules:
  - Shifts use b[4:0].
  - SLT is signed, SLTU is unsigned.
  - An undefined op yields result 0. It is still returned as a normal response; no error flag.
- Reset mid-operation: a pending response is discarded, rsp_valid drops asynchronously, and the pointer returns to N_REQ-1. Requesters must re-present their requests.

Decomposition:
- Shared package risc_pkg:
  - Existing alu_op_t (ADD, SUB, SLL, SRL, SRA, XOR, OR, AND, SLT, SLTU) is reused unchanged.
  - Add typedef alu_req_t {alu_op_t op; logic [31:0] a, b;}. The tag stays a separate port because its width is parameterized.
- Sub-modules:
  - rr_pick: purely combinational, inputs req vector and last_grant, outputs one-hot win plus win index. Reusable by later arbiters.
  - The shared ALU is instantiated once inside alu_rr_arbiter.

Test Plan:
- Reset, then req_valid=01, op=ADD, a=5, b=7, tag=3, rsp_ready=1 → req_ready=01 in the same cycle. Next cycle rsp_valid=1, rsp_id=0, rsp_tag=3, rsp_res=12.
- Both valid and held for 4 cycles: req0 SUB 10-3, req1 SRA a=0x80000000 b=4; rsp_ready=1 → grants 0,1,0,1. Results alternate 7 and 0xF8000000.
- Back-pressure:
  - Result pending with rsp_ready=0 for 3 cycles, req1 valid → req_ready=00 and rsp fields stable.
  - Raise rsp_ready → req1 accepted the same cycle; the next rsp has id=1 with no bubble cycle.
- Blocked grant does not rotate the pointer: last_grant=0, req1 valid but slot blocked for 2 cycles, then req0 also becomes valid as the slot frees → req1 wins first.
- Compare ops: SLT a=0xFFFFFFFF b=1 → 1. SLTU with the same operands → 0. SLL a=1 b=0x21 → 2. Undefined op → 0 with rsp_valid=1.
- rst asserted mid-cycle while rsp_valid=1 → rsp_valid=0 immediately without a clock edge. After release, both requesters valid → requester 0 is granted first.
